// File: rtl/core_pkg.sv
// Shared constants and the fetch-queue entry type for the instruction-fetch slice.
package core_pkg;
  localparam int PC_W = 10;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h00000013;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input and decode handshake.
interface if_stage_if #(
  parameter int PC_W = 10
);
  logic            imem_en;
  logic [PC_W-3:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [PC_W-1:0] inst_pc;

  // Handshake: an instruction transfers on a rising clk when inst_valid & inst_ready;
  // inst_valid/inst/inst_pc never depend on inst_ready, and stay stable until taken or flushed.
  modport master (
    output imem_en, imem_addr, inst_valid, inst, inst_pc,
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_en, imem_addr, inst_valid, inst, inst_pc,
    output imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Circular instruction queue with push, pop and a flush that overrides both.
module fetch_fifo #(
  parameter int DEPTH = 3,
  parameter int W     = 42
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_wdata,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [W-1:0]                 o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-limited requests to a sync-read imem, and redirect flush.
module if_stage
  import core_pkg::INST_W;
  import core_pkg::NOP_INST;
#(
  parameter int              PC_W     = 10,
  parameter int              DEPTH    = 3,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic       clk,
  input logic       rstn,
  if_stage_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  logic            r_running;
  logic            r_inflight;
  logic            r_squash;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_inflight_pc;
  logic [PC_W-1:0] r_last_pc;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_credit;
  logic            w_req;
  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  entry_t          w_wdata;
  entry_t          w_head;
  logic [$bits(entry_t)-1:0] w_head_bits;

  // Entries held plus the read already in flight must fit, so a returning word always has room.
  assign w_credit = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_req    = r_running & ~bus.redirect_valid & (w_credit < (CW+1)'(DEPTH));
  assign w_push   = r_inflight & ~r_squash & ~bus.redirect_valid;
  assign w_valid  = (w_count != '0);
  assign w_pop    = w_valid & bus.inst_ready;
  assign w_wdata  = '{pc: r_inflight_pc, inst: bus.imem_rdata};
  assign w_head   = entry_t'(w_head_bits);

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .o_rdata (w_head_bits),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_running     <= 1'b0;
      r_inflight    <= 1'b0;
      r_squash      <= 1'b0;
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_last_pc     <= '0;
    end else begin
      r_running <= 1'b1;
      if (w_valid) r_last_pc <= w_head.pc;
      if (bus.redirect_valid) begin
        r_pc       <= {bus.redirect_pc[PC_W-1:2], 2'b00};
        r_inflight <= 1'b0;
        r_squash   <= r_inflight;
      end else begin
        r_squash <= 1'b0;
        if (w_req) begin
          r_pc          <= r_pc + PC_W'(4);
          r_inflight    <= 1'b1;
          r_inflight_pc <= r_pc;
        end else begin
          r_inflight <= 1'b0;
        end
      end
    end
  end

  assign bus.imem_en    = w_req;
  assign bus.imem_addr  = r_pc[PC_W-1:2];
  assign bus.inst_valid = w_valid;
  assign bus.inst       = w_valid ? w_head.inst : NOP_INST;
  assign bus.inst_pc    = w_valid ? w_head.pc : r_last_pc;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: two instances (reset PC 0 and 0x3F8) against a word-k = 0x1000+k memory.
module tb_if_stage;
  import core_pkg::*;

  localparam int EW = $bits(fetch_entry_t);

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   b_pops = 0;

  logic [EW-1:0] exp_a_q[$];
  logic [EW-1:0] exp_b_q[$];
  fetch_entry_t  e_a;
  fetch_entry_t  e_b;

  always #5 clk = ~clk;

  if_stage_if #(.PC_W(10)) bus_a ();
  if_stage_if #(.PC_W(10)) bus_b ();

  if_stage #(.PC_W(10), .DEPTH(3), .RESET_PC(10'h000)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  if_stage #(.PC_W(10), .DEPTH(3), .RESET_PC(10'h3F8)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));

  // Synchronous-read memories: data for the address requested last cycle.
  always @(posedge clk) if (bus_a.imem_en) bus_a.imem_rdata <= 32'h1000 + 32'(bus_a.imem_addr);
  always @(posedge clk) if (bus_b.imem_en) bus_b.imem_rdata <= 32'h1000 + 32'(bus_b.imem_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [9:0] pc0, input int n);
    logic [9:0] pc;
    for (int k = 0; k < n; k++) begin
      pc = pc0 + 10'(4 * k);
      exp_a_q.push_back({pc, 32'h1000 + 32'(pc[9:2])});
    end
  endtask

  task automatic push_b(input logic [9:0] pc0, input int n);
    logic [9:0] pc;
    for (int k = 0; k < n; k++) begin
      pc = pc0 + 10'(4 * k);
      exp_b_q.push_back({pc, 32'h1000 + 32'(pc[9:2])});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every accepted instruction is compared against the head of its expected queue.
  always @(negedge clk) begin
    if (rstn && bus_a.inst_valid && bus_a.inst_ready) begin
      if (exp_a_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected: got pc 0x%0h expected no instruction", bus_a.inst_pc);
      end else begin
        e_a = fetch_entry_t'(exp_a_q.pop_front());
        chk("a_inst_pc", 64'(bus_a.inst_pc), 64'(e_a.pc));
        chk("a_inst", 64'(bus_a.inst), 64'(e_a.inst));
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && bus_b.inst_valid && bus_b.inst_ready) begin
      b_pops++;
      if (exp_b_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected: got pc 0x%0h expected no instruction", bus_b.inst_pc);
      end else begin
        e_b = fetch_entry_t'(exp_b_q.pop_front());
        chk("b_inst_pc", 64'(bus_b.inst_pc), 64'(e_b.pc));
        chk("b_inst", 64'(bus_b.inst), 64'(e_b.inst));
      end
    end
  end

  initial begin
    bus_a.inst_ready = 1'b1; bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = '0;
    bus_b.inst_ready = 1'b1; bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = '0;
    #1 rstn = 1'b0;
    #1;
    chk("rst_imem_en", 64'(bus_a.imem_en), 64'd0);
    chk("rst_imem_addr", 64'(bus_a.imem_addr), 64'h0);
    chk("rst_inst_valid", 64'(bus_a.inst_valid), 64'd0);
    chk("rst_inst", 64'(bus_a.inst), 64'h13);
    chk("rst_inst_pc", 64'(bus_a.inst_pc), 64'h0);
    chk("rst_b_imem_addr", 64'(bus_b.imem_addr), 64'hFE);
    chk("rst_b_inst_pc", 64'(bus_b.inst_pc), 64'h0);
    push_a(10'h000, 40);
    push_b(10'h3F8, 200);

    // Startup: cycle 0 idle, request in cycle 1, first valid in cycle 3.
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1 chk("c0_imem_en", 64'(bus_a.imem_en), 64'd0);
    cyc(); #1;
    chk("c1_imem_en", 64'(bus_a.imem_en), 64'd1);
    chk("c1_imem_addr", 64'(bus_a.imem_addr), 64'h0);
    chk("c1_b_imem_addr", 64'(bus_b.imem_addr), 64'hFE);
    cyc(); #1 chk("c2_inst_valid", 64'(bus_a.inst_valid), 64'd0);
    cyc(); #1;
    chk("c3_inst_valid", 64'(bus_a.inst_valid), 64'd1);
    chk("c3_inst_pc", 64'(bus_a.inst_pc), 64'h0);
    chk("c3_inst", 64'(bus_a.inst), 64'h1000);
    repeat (6) begin
      cyc(); #1;
      chk("stream_valid", 64'(bus_a.inst_valid), 64'd1);
      chk("stream_imem_en", 64'(bus_a.imem_en), 64'd1);
    end

    // Backpressure: five stalled cycles, queue fills to DEPTH and requests stop.
    cyc(); bus_a.inst_ready = 1'b0;
    repeat (4) begin
      cyc(); #1;
      chk("bp_imem_en", 64'(bus_a.imem_en), 64'd0);
      chk("bp_inst_valid", 64'(bus_a.inst_valid), 64'd1);
    end
    cyc(); bus_a.inst_ready = 1'b1;
    #1 chk("bp_pop_cycle_en", 64'(bus_a.imem_en), 64'd0);
    cyc(); #1 chk("bp_resume_en", 64'(bus_a.imem_en), 64'd1);
    repeat (4) cyc();

    // Redirect with a read in flight and a coinciding pop.
    cyc(); bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 10'h103;
    #1;
    chk("rd_imem_en", 64'(bus_a.imem_en), 64'd0);
    chk("rd_pop_valid", 64'(bus_a.inst_valid), 64'd1);
    cyc(); bus_a.redirect_valid = 1'b0;
    exp_a_q.delete();
    push_a(10'h100, 20);
    #1;
    chk("rd1_inst_valid", 64'(bus_a.inst_valid), 64'd0);
    chk("rd1_imem_en", 64'(bus_a.imem_en), 64'd1);
    chk("rd1_imem_addr", 64'(bus_a.imem_addr), 64'h40);
    cyc(); #1 chk("rd2_inst_valid", 64'(bus_a.inst_valid), 64'd0);
    cyc(); #1;
    chk("rd3_inst_valid", 64'(bus_a.inst_valid), 64'd1);
    chk("rd3_inst_pc", 64'(bus_a.inst_pc), 64'h100);
    repeat (3) cyc();

    // Back-to-back redirects: only the second target is fetched.
    cyc(); bus_a.redirect_valid = 1'b1; bus_a.redirect_pc = 10'h040;
    #1 chk("bb_pop_valid", 64'(bus_a.inst_valid), 64'd1);
    cyc(); bus_a.redirect_pc = 10'h080;
    #1;
    chk("bb2_imem_en", 64'(bus_a.imem_en), 64'd0);
    chk("bb2_inst_valid", 64'(bus_a.inst_valid), 64'd0);
    cyc(); bus_a.redirect_valid = 1'b0;
    exp_a_q.delete();
    push_a(10'h080, 20);
    #1 chk("bb3_imem_addr", 64'(bus_a.imem_addr), 64'h20);
    cyc(); #1 chk("bb4_inst_valid", 64'(bus_a.inst_valid), 64'd0);
    cyc(); #1;
    chk("bb5_inst_valid", 64'(bus_a.inst_valid), 64'd1);
    chk("bb5_inst_pc", 64'(bus_a.inst_pc), 64'h80);
    repeat (3) cyc();

    // Reset while the queue is full, then a clean restart.
    cyc(); bus_a.inst_ready = 1'b0;
    repeat (4) cyc();
    #1 chk("mr_full_valid", 64'(bus_a.inst_valid), 64'd1);
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    chk("mr_imem_en", 64'(bus_a.imem_en), 64'd0);
    chk("mr_imem_addr", 64'(bus_a.imem_addr), 64'h0);
    chk("mr_inst_valid", 64'(bus_a.inst_valid), 64'd0);
    chk("mr_inst", 64'(bus_a.inst), 64'h13);
    chk("mr_inst_pc", 64'(bus_a.inst_pc), 64'h0);
    chk("mr_b_imem_en", 64'(bus_b.imem_en), 64'd0);
    chk("mr_b_imem_addr", 64'(bus_b.imem_addr), 64'hFE);
    exp_a_q.delete();
    exp_b_q.delete();
    push_a(10'h000, 20);
    push_b(10'h3F8, 200);
    bus_a.inst_ready = 1'b1;
    @(posedge clk); #1 rstn = 1'b1;
    #1 chk("mr_c0_imem_en", 64'(bus_a.imem_en), 64'd0);
    cyc(); #1;
    chk("mr_c1_imem_en", 64'(bus_a.imem_en), 64'd1);
    chk("mr_c1_imem_addr", 64'(bus_a.imem_addr), 64'h0);
    cyc(); #1 chk("mr_c2_inst_valid", 64'(bus_a.inst_valid), 64'd0);
    cyc(); #1;
    chk("mr_c3_inst_valid", 64'(bus_a.inst_valid), 64'd1);
    chk("mr_c3_inst_pc", 64'(bus_a.inst_pc), 64'h0);
    repeat (10) cyc();

    chk("b_wrap_stream_seen", 64'(b_pops >= 4), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
